// File: rtl/perf_counter_bank.sv
// perf_counter_bank: per-channel active-cycle totals, run latency, completed-run count, sticky ovf/abort.
// Latency: every output is registered; an event sampled at edge k is visible after edge k.
// Backpressure: none; the bank only observes start/done, sampling them every cycle and never stalling.
// Build option: define PERF_MINMAX_EN to add per-channel min/max latency registers (default: tied to 0).
module perf_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int RUN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       done,
    output logic [NUM_CH*CNT_W-1:0] total_cnt,
    output logic [NUM_CH*CNT_W-1:0] last_lat,
    output logic [NUM_CH*RUN_W-1:0] run_cnt,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       ovf,
    output logic [NUM_CH-1:0]       abort,
    output logic [NUM_CH*CNT_W-1:0] min_lat,
    output logic [NUM_CH*CNT_W-1:0] max_lat
);

    // Run tracker states. HOLD waits for start to drop so that a start
    // level that stays high after done cannot launch a second run.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } run_st_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        run_st_t            st_q;
        run_st_t            st_d;
        logic [CNT_W-1:0]   tot_q;
        logic [CNT_W-1:0]   cur_q;
        logic [CNT_W-1:0]   cur_d;
        logic [CNT_W-1:0]   lat_q;
        logic [RUN_W-1:0]   runs_q;
        logic               ovf_q;
        logic               abort_q;

        // Per-cycle events decoded from the FSM and the raw inputs.
        logic               tot_inc;
        logic               cur_inc;
        logic               cap;
        logic               abort_set;
        logic               ovf_set;
        logic               tot_sat;
        logic               cur_sat;
        logic               runs_sat;

        assign tot_sat  = &tot_q;
        assign cur_sat  = &cur_q;
        assign runs_sat = &runs_q;

        // Active cycle for the legacy total: start without done, regardless of FSM state.
        assign tot_inc  = start[i] & ~done[i];

        // Next-state and run-event decode for the latency tracker.
        always_comb begin
            st_d      = st_q;
            cur_d     = cur_q;
            cur_inc   = 1'b0;
            cap       = 1'b0;
            abort_set = 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (start[i] && !done[i]) begin
                        st_d  = ST_RUN;
                        cur_d = CNT_W'(1);
                    end else if (start[i] && done[i]) begin
                        // Zero-length run: nothing to measure, just wait for start to fall.
                        st_d = ST_HOLD;
                    end
                end
                ST_RUN: begin
                    if (done[i]) begin
                        cap  = 1'b1;
                        st_d = ST_HOLD;
                    end else if (!start[i]) begin
                        abort_set = 1'b1;
                        st_d      = ST_IDLE;
                    end else begin
                        cur_inc = 1'b1;
                        if (!cur_sat) begin
                            cur_d = cur_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!start[i]) begin
                        st_d = ST_IDLE;
                    end
                end
                default: begin
                    st_d = ST_IDLE;
                end
            endcase
        end

        // Any increment attempted on an all-ones counter is reported, the counter itself holds.
        assign ovf_set = (tot_inc && tot_sat) || (cur_inc && cur_sat) || (cap && runs_sat);

        // Channel state registers; clr acts as a synchronous reset that overrides all events.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                st_q    <= ST_IDLE;
                tot_q   <= '0;
                cur_q   <= '0;
                lat_q   <= '0;
                runs_q  <= '0;
                ovf_q   <= 1'b0;
                abort_q <= 1'b0;
            end else if (clr) begin
                st_q    <= ST_IDLE;
                tot_q   <= '0;
                cur_q   <= '0;
                lat_q   <= '0;
                runs_q  <= '0;
                ovf_q   <= 1'b0;
                abort_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                cur_q <= cur_d;
                if (tot_inc && !tot_sat) begin
                    tot_q <= tot_q + CNT_W'(1);
                end
                if (cap) begin
                    // A saturated run_cur is captured as-is.
                    lat_q <= cur_q;
                    if (!runs_sat) begin
                        runs_q <= runs_q + RUN_W'(1);
                    end
                end
                if (ovf_set) begin
                    ovf_q <= 1'b1;
                end
                if (abort_set) begin
                    abort_q <= 1'b1;
                end
            end
        end

        assign total_cnt[i*CNT_W +: CNT_W] = tot_q;
        assign last_lat[i*CNT_W +: CNT_W]  = lat_q;
        assign run_cnt[i*RUN_W +: RUN_W]   = runs_q;
        assign busy[i]                     = (st_q == ST_RUN);
        assign ovf[i]                      = ovf_q;
        assign abort[i]                    = abort_q;

`ifdef PERF_MINMAX_EN
        logic [CNT_W-1:0] min_q;
        logic [CNT_W-1:0] max_q;
        logic             seen_q;

        // Min/max of captured latencies; the first capture after reset/clr seeds both.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                min_q  <= '0;
                max_q  <= '0;
                seen_q <= 1'b0;
            end else if (clr) begin
                min_q  <= '0;
                max_q  <= '0;
                seen_q <= 1'b0;
            end else if (cap) begin
                seen_q <= 1'b1;
                if (!seen_q) begin
                    min_q <= cur_q;
                    max_q <= cur_q;
                end else begin
                    if (cur_q < min_q) begin
                        min_q <= cur_q;
                    end
                    if (cur_q > max_q) begin
                        max_q <= cur_q;
                    end
                end
            end
        end

        assign min_lat[i*CNT_W +: CNT_W] = min_q;
        assign max_lat[i*CNT_W +: CNT_W] = max_q;
`else
        assign min_lat[i*CNT_W +: CNT_W] = '0;
        assign max_lat[i*CNT_W +: CNT_W] = '0;
`endif
    end : g_ch

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a 4-channel 32-bit instance plus a 1-channel instance
// with CNT_W=4 / RUN_W=2 for saturation. A run-level model predicts every output each
// cycle; directed scenarios add literal expectations.
module tb_perf_counter_bank;

    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int RW  = 16;
    localparam int SCW = 4;
    localparam int SRW = 2;
    localparam int MCH = NCH + 1;   // model channel NCH is the small instance

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  clr;
    logic [NCH-1:0]        start;
    logic [NCH-1:0]        done;
    logic [NCH*CW-1:0]     total_cnt;
    logic [NCH*CW-1:0]     last_lat;
    logic [NCH*RW-1:0]     run_cnt;
    logic [NCH-1:0]        busy;
    logic [NCH-1:0]        ovf;
    logic [NCH-1:0]        abort;
    logic [NCH*CW-1:0]     min_lat;
    logic [NCH*CW-1:0]     max_lat;

    logic [0:0]            s_start;
    logic [0:0]            s_done;
    logic [SCW-1:0]        s_total;
    logic [SCW-1:0]        s_last;
    logic [SRW-1:0]        s_run;
    logic [0:0]            s_busy;
    logic [0:0]            s_ovf;
    logic [0:0]            s_abort;
    logic [SCW-1:0]        s_min;
    logic [SCW-1:0]        s_max;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .RUN_W(RW)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .start     (start),
        .done      (done),
        .total_cnt (total_cnt),
        .last_lat  (last_lat),
        .run_cnt   (run_cnt),
        .busy      (busy),
        .ovf       (ovf),
        .abort     (abort),
        .min_lat   (min_lat),
        .max_lat   (max_lat)
    );

    perf_counter_bank #(.NUM_CH(1), .CNT_W(SCW), .RUN_W(SRW)) u_small (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .start     (s_start),
        .done      (s_done),
        .total_cnt (s_total),
        .last_lat  (s_last),
        .run_cnt   (s_run),
        .busy      (s_busy),
        .ovf       (s_ovf),
        .abort     (s_abort),
        .min_lat   (s_min),
        .max_lat   (s_max)
    );

    always #5 clk = ~clk;

    // ---------------- model: unbounded counts, clipped when read ----------------
    longint cmax[MCH];
    longint rmax[MCH];
    longint act_cycles[MCH];   // edges with start && !done since reset/clr
    longint run_len[MCH];      // length of the run in progress
    longint lat_m[MCH];
    longint runs_m[MCH];
    longint mn_m[MCH];
    longint mx_m[MCH];
    bit     in_run[MCH];
    bit     wait_rel[MCH];     // run finished, waiting for start to drop
    bit     ovf_m[MCH];
    bit     abt_m[MCH];
    bit     seen_m[MCH];

    function automatic longint clip(longint v, longint m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_step();
        bit s;
        bit d;
        longint l;
        for (int c = 0; c < MCH; c++) begin
            if (!rstn || clr) begin
                act_cycles[c] = 0; run_len[c] = 0; lat_m[c] = 0; runs_m[c] = 0;
                mn_m[c] = 0; mx_m[c] = 0; in_run[c] = 0; wait_rel[c] = 0;
                ovf_m[c] = 0; abt_m[c] = 0; seen_m[c] = 0;
            end else begin
                s = (c < NCH) ? start[c] : s_start[0];
                d = (c < NCH) ? done[c]  : s_done[0];
                if (s && !d) begin
                    act_cycles[c]++;
                    if (act_cycles[c] > cmax[c]) ovf_m[c] = 1;
                end
                if (in_run[c]) begin
                    if (d) begin
                        l = clip(run_len[c], cmax[c]);
                        lat_m[c] = l;
                        runs_m[c]++;
                        if (runs_m[c] > rmax[c]) ovf_m[c] = 1;
                        mn_m[c] = (!seen_m[c] || l < mn_m[c]) ? l : mn_m[c];
                        mx_m[c] = (!seen_m[c] || l > mx_m[c]) ? l : mx_m[c];
                        seen_m[c] = 1;
                        in_run[c] = 0;
                        wait_rel[c] = 1;
                    end else if (!s) begin
                        abt_m[c] = 1;
                        in_run[c] = 0;
                    end else begin
                        run_len[c]++;
                        if (run_len[c] > cmax[c]) ovf_m[c] = 1;
                    end
                end else if (wait_rel[c]) begin
                    if (!s) wait_rel[c] = 0;
                end else if (s) begin
                    if (d) wait_rel[c] = 1;
                    else begin in_run[c] = 1; run_len[c] = 1; end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rstn);
        model_step();
    end

    // ---------------- DUT accessors ----------------
    function automatic logic [63:0] a_tot(int c);
        return (c < NCH) ? 64'(total_cnt[c*CW +: CW]) : 64'(s_total);
    endfunction
    function automatic logic [63:0] a_lat(int c);
        return (c < NCH) ? 64'(last_lat[c*CW +: CW]) : 64'(s_last);
    endfunction
    function automatic logic [63:0] a_run(int c);
        return (c < NCH) ? 64'(run_cnt[c*RW +: RW]) : 64'(s_run);
    endfunction
    function automatic logic [63:0] a_busy(int c);
        return (c < NCH) ? 64'(busy[c]) : 64'(s_busy[0]);
    endfunction
    function automatic logic [63:0] a_ovf(int c);
        return (c < NCH) ? 64'(ovf[c]) : 64'(s_ovf[0]);
    endfunction
    function automatic logic [63:0] a_abt(int c);
        return (c < NCH) ? 64'(abort[c]) : 64'(s_abort[0]);
    endfunction
    function automatic logic [63:0] a_min(int c);
        return (c < NCH) ? 64'(min_lat[c*CW +: CW]) : 64'(s_min);
    endfunction
    function automatic logic [63:0] a_max(int c);
        return (c < NCH) ? 64'(max_lat[c*CW +: CW]) : 64'(s_max);
    endfunction

    task automatic chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ch%0d got=%0d want=%0d", name, ch, act, exp);
        end
    endtask

    // Compare every output of every channel against the model each cycle.
    initial forever begin
        @(posedge clk);
        #2;
        if (cmp_en) begin
            for (int c = 0; c < MCH; c++) begin
                chk("total_cnt", c, a_tot(c), 64'(clip(act_cycles[c], cmax[c])));
                chk("last_lat",  c, a_lat(c), 64'(lat_m[c]));
                chk("run_cnt",   c, a_run(c), 64'(clip(runs_m[c], rmax[c])));
                chk("busy",      c, a_busy(c), 64'(in_run[c]));
                chk("ovf",       c, a_ovf(c), 64'(ovf_m[c]));
                chk("abort",     c, a_abt(c), 64'(abt_m[c]));
`ifdef PERF_MINMAX_EN
                chk("min_lat",   c, a_min(c), 64'(mn_m[c]));
                chk("max_lat",   c, a_max(c), 64'(mx_m[c]));
`else
                chk("min_lat",   c, a_min(c), 64'd0);
                chk("max_lat",   c, a_max(c), 64'd0);
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int bcnt;
        for (int c = 0; c < MCH; c++) begin
            cmax[c] = (c < NCH) ? ((longint'(1) << CW) - 1) : ((longint'(1) << SCW) - 1);
            rmax[c] = (c < NCH) ? ((longint'(1) << RW) - 1) : ((longint'(1) << SRW) - 1);
        end
        start = '0; done = '0; s_start = '0; s_done = '0; clr = 1'b0; rstn = 1'b0;
        repeat (3) tick();
        chk("rst_total", 0, 64'(total_cnt), 64'd0);
        chk("rst_busy",  0, 64'(busy), 64'd0);
        chk("rst_flags", 0, 64'({ovf, abort}), 64'd0);
        chk("rst_small", 4, 64'({s_total, s_run, s_busy, s_ovf}), 64'd0);
        rstn = 1'b1;
        tick();
        cmp_en = 1'b1;

        // Channel 0: 10 start cycles, done for one, start drops.
        bcnt = 0;
        start[0] = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t == 10) done[0] = 1'b1;
            if (t == 11) begin start[0] = 1'b0; done[0] = 1'b0; end
            tick();
            if (busy[0]) bcnt++;
        end
        tick();
        chk("t1_total", 0, a_tot(0), 64'd10);
        chk("t1_lat",   0, a_lat(0), 64'd10);
        chk("t1_runs",  0, a_run(0), 64'd1);
        chk("t1_busycycles", 0, 64'(bcnt), 64'd10);
        chk("t1_abort", 0, a_abt(0), 64'd0);

        // Channel 1: 5 start cycles, dropped without done.
        start[1] = 1'b1;
        repeat (5) tick();
        start[1] = 1'b0;
        repeat (2) tick();
        chk("t2_abort", 1, a_abt(1), 64'd1);
        chk("t2_runs",  1, a_run(1), 64'd0);
        chk("t2_lat",   1, a_lat(1), 64'd0);
        chk("t2_total", 1, a_tot(1), 64'd5);

        // Clear, then concurrent runs of 3 (ch0) and 7 (ch1), then a run of 4 on ch0.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_total0", 0, a_tot(0), 64'd0);
        chk("clr_abort1", 1, a_abt(1), 64'd0);
        for (int t = 0; t < 9; t++) begin
            start[0] = (t < 4); done[0] = (t == 3);
            start[1] = (t < 8); done[1] = (t == 7);
            tick();
        end
        tick();
        for (int t = 0; t < 6; t++) begin
            start[0] = (t < 5); done[0] = (t == 4);
            tick();
        end
        tick();
        chk("t3_lat0",  0, a_lat(0), 64'd4);
        chk("t3_runs0", 0, a_run(0), 64'd2);
        chk("t3_lat1",  1, a_lat(1), 64'd7);
`ifdef PERF_MINMAX_EN
        chk("t3_min0",  0, a_min(0), 64'd3);
        chk("t3_max0",  0, a_max(0), 64'd4);
`endif

        // Small instance: 20 start cycles then done -> saturation at 15.
        s_start = 1'b1;
        repeat (20) tick();
        s_done = 1'b1;
        tick();
        s_start = 1'b0; s_done = 1'b0;
        tick();
        chk("t4_total", 4, a_tot(4), 64'd15);
        chk("t4_lat",   4, a_lat(4), 64'd15);
        chk("t4_ovf",   4, a_ovf(4), 64'd1);
        chk("t4_runs",  4, a_run(4), 64'd1);
        // Three more 2-cycle runs: run_cnt stops at 3.
        repeat (3) begin
            s_start = 1'b1;
            repeat (2) tick();
            s_done = 1'b1;
            tick();
            s_start = 1'b0; s_done = 1'b0;
            tick();
        end
        chk("t4_runsat", 4, a_run(4), 64'd3);
        chk("t4_lat2",   4, a_lat(4), 64'd2);

        // clr mid-run on channel 2 with start still high.
        start[2] = 1'b1;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr_busy",  2, 64'(busy), 64'd0);
        chk("t5_clr_total", 2, a_tot(2), 64'd0);
        chk("t5_clr_small", 4, 64'({s_total, s_run, s_ovf}), 64'd0);
        repeat (3) tick();
        chk("t5_rerun", 2, a_busy(2), 64'd1);
        // Asynchronous reset mid-run.
        rstn = 1'b0;
        #1;
        chk("t5_arst_total", 2, a_tot(2), 64'd0);
        chk("t5_arst_busy",  2, 64'(busy), 64'd0);
        tick();
        chk("t5_rst_lat", 0, 64'(last_lat), 64'd0);
        rstn = 1'b1;
        start[2] = 1'b0;
        tick();

        // Channel 3: start and done together from IDLE, start held high afterwards.
        bcnt = 0;
        start[3] = 1'b1; done[3] = 1'b1;
        repeat (2) begin tick(); if (busy[3]) bcnt++; end
        done[3] = 1'b0;
        repeat (3) begin tick(); if (busy[3]) bcnt++; end
        chk("t6_busycycles", 3, 64'(bcnt), 64'd0);
        chk("t6_runs", 3, a_run(3), 64'd0);
        chk("t6_lat",  3, a_lat(3), 64'd0);
        start[3] = 1'b0;
        tick();
        start[3] = 1'b1;
        tick();
        chk("t6_release", 3, a_busy(3), 64'd1);
        start[3] = 1'b0;
        repeat (2) tick();
        chk("t6_abort", 3, a_abt(3), 64'd1);

        cmp_en = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Multi-channel performance-counter bank for the conv/systolic datapath. Generalised successor of the single-channel conv clock counter.
- Per channel it keeps:
  - a legacy-compatible active-cycle total;
  - a per-run latency measurement, captured through a small FSM;
  - a completed-run count;
  - overflow and abort status.
- One instance sits at the top level and observes the start/done pairs of the conv, pool and FC engines.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 32, width of the total-cycle and latency counters.
- RUN_W, 16, width of the completed-run counter.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of all channels; highest priority after reset.
- start  input  NUM_CH  per-channel start level; bit i belongs to channel i.
- done  input  NUM_CH  per-channel done level.
- total_cnt  output  NUM_CH*CNT_W  per-channel active-cycle totals; channel i occupies bits [i*CNT_W +: CNT_W].
- last_lat  output  NUM_CH*CNT_W  latency of the most recent completed run, per channel.
- run_cnt  output  NUM_CH*RUN_W  number of completed runs, per channel.
- busy  output  NUM_CH  high while the channel FSM is in RUN.
- ovf  output  NUM_CH  sticky: a counter of that channel saturated.
- abort  output  NUM_CH  sticky: a run ended without done.
- min_lat, max_lat  output  NUM_CH*CNT_W each  see Optional Feature.

Behaviour:
- Reset (rstn=0, asynchronous): every output register is 0 and every FSM is IDLE.
- clr=1 at a rising edge: same effect as reset, applied synchronously. clr overrides every other event in that cycle.
- Channels are fully independent. All outputs are registered, so updates are visible the cycle after the triggering edge.
- total_cnt[i]:
  - increments by 1 at each edge where start[i]=1 and done[i]=0, independent of FSM state;
  - otherwise it holds its value.
- Latency tracking uses an internal run_cur[i] (CNT_W bits) and a per-channel FSM with states IDLE, RUN and HOLD.
- IDLE:
  - start=1, done=0: go to RUN; run_cur <= 1.
  - start=1, done=1: go to HOLD with no capture.
  - otherwise stay in IDLE.
- RUN (busy=1):
  - done=1: last_lat <= run_cur; run_cnt <= run_cnt+1; go to HOLD.
  - start=0, done=0: abort <= 1; go to IDLE; no capture.
  - otherwise: run_cur <= run_cur+1.
- HOLD:
  - start=0: go to IDLE.
  - otherwise stay in HOLD. This prevents a still-high start from re-triggering a run.
- Consequence: for start rising at edge k and done asserted at edge k+N, last_lat equals N. This matches the total_cnt increment for that run.
- Saturation:
  - total_cnt, run_cur and run_cnt stop at all-ones and never wrap.
  - Any increment attempted at all-ones sets ovf[i].
  - A saturated run_cur is captured unchanged into last_lat.
- ovf and abort stay set until reset or clr.
- Unused upper lanes do not exist; all buses are sized exactly by NUM_CH.

Optional Feature:
- Macro: PERF_MINMAX_EN.
- Defined: at each capture, min_lat[i] and max_lat[i] are updated.
  - First capture after reset or clr: both take the captured value.
  - Later captures: min_lat takes the smaller and max_lat takes the larger of its current value and the captured value.
  - Both reset to 0.
- Undefined: min_lat and max_lat are constant 0 and no registers are inferred for them.

Test Plan:
- Channel 0: start high for 10 cycles, then done for 1 cycle, then start low. Required: total_cnt0=10, last_lat0=10, run_cnt0=1, busy0 high for exactly 10 cycles, abort0=0.
- Channel 1: start high 5 cycles, then dropped without done. Required: abort1=1, run_cnt1=0, last_lat1=0, total_cnt1=5.
- Two channels running concurrently with latencies 3 and 7, then a third run of length 4 on channel 0. Required: last_lat0=4, run_cnt0=2, last_lat1=7; with PERF_MINMAX_EN, min_lat0=3 and max_lat0=4.
- CNT_W=4: start held 20 cycles, then done. Required: total_cnt=15, last_lat=15, ovf=1.
- clr pulsed mid-run, then rstn pulsed low mid-run. Required: in both cases all outputs are 0 on the next cycle and the FSM is IDLE.
- start and done asserted in the same cycle from IDLE, with start then held high. Required: no count, no capture, FSM stays in HOLD until start falls.
